// File: rtl/led_pkg.sv
// Shared definitions for the LED sequence driver: mode encoding and the
// default command codes for the enable bus.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  localparam logic [2:0] EN_CODE_DEFAULT  = 3'd4;
  localparam logic [2:0] CLR_CODE_DEFAULT = 3'd0;

endpackage

// File: rtl/led_tick_div.sv
// Free-running step divider. cnt counts 0..DIV-1 and phase flips each time
// cnt wraps; tick is high during the cycle whose edge performs the wrap.
// A restart forces cnt back to 0 and phase to 1 without producing a tick.
module led_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic phase_nxt
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_nxt;
  logic       phase_q;

  // Next counter/phase values; phase_nxt is exported so the parent can
  // register its LED output from the same next-state the divider adopts.
  always_comb begin
    tick      = (cnt_q == LAST) && !restart;
    cnt_nxt   = cnt_q + 8'd1;
    phase_nxt = phase_q;
    if (restart) begin
      cnt_nxt   = 8'd0;
      phase_nxt = 1'b1;
    end else if (tick) begin
      cnt_nxt   = 8'd0;
      phase_nxt = ~phase_q;
    end
  end

  // Counter and phase registers with synchronous reset to the restart state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_nxt;
      phase_q <= phase_nxt;
    end
  end

endmodule

// File: rtl/led_seq_driver.sv
// LED sequence driver: latches an LED index on an enable strobe and shows it
// directly, held, blinking, or as a chase that walks across all LEDs.
// The LED output is registered from the next-state values so a strobe is
// visible one edge later.
module led_seq_driver
  import led_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter logic [2:0]  EN_CODE    = EN_CODE_DEFAULT,
  parameter logic [2:0]  CLR_CODE   = CLR_CODE_DEFAULT,
  parameter int unsigned BLINK_DIV  = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              enable,
  input  logic [SEL_W-1:0]        switch,
  input  logic [1:0]              mode,
  output logic [(2**SEL_W)-1:0]   led
);

  localparam int unsigned N_LED = 2 ** SEL_W;
  localparam logic [N_LED-1:0] LED_OFF = ACTIVE_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};

  logic              en_hit;
  logic              clr_hit;
  logic              tick;
  logic              phase_nxt;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_nxt;
  logic [SEL_W-1:0]  pos_q;
  logic [SEL_W-1:0]  pos_nxt;
  logic              valid_q;
  logic              valid_nxt;
  logic [N_LED-1:0]  pattern;
  logic [N_LED-1:0]  led_nxt;

  led_tick_div #(
    .DIV(BLINK_DIV)
  ) u_tick_div (
    .clk      (clk),
    .rst      (rst),
    .restart  (en_hit),
    .tick     (tick),
    .phase_nxt(phase_nxt)
  );

  // Decode commands, compute next selection state and the one-hot pattern
  // that the LED register captures on this edge.
  always_comb begin
    en_hit    = (enable == EN_CODE);
    clr_hit   = !en_hit && (enable == CLR_CODE);
    sel_nxt   = sel_q;
    pos_nxt   = pos_q;
    valid_nxt = valid_q;
    if (en_hit) begin
      sel_nxt   = switch;
      pos_nxt   = switch;
      valid_nxt = 1'b1;
    end else begin
      if (clr_hit) begin
        valid_nxt = 1'b0;
      end
      if (tick) begin
        pos_nxt = pos_q + SEL_W'(1);
      end
    end

    pattern = '0;
    case (mode_t'(mode))
      MODE_DIRECT: if (en_hit)                  pattern[switch]  = 1'b1;
      MODE_HOLD:   if (valid_nxt)               pattern[sel_nxt] = 1'b1;
      MODE_BLINK:  if (valid_nxt && phase_nxt)  pattern[sel_nxt] = 1'b1;
      MODE_CHASE:  if (valid_nxt)               pattern[pos_nxt] = 1'b1;
      default:     pattern = '0;
    endcase

    led_nxt = ACTIVE_LOW ? ~pattern : pattern;
  end

  // Selection state and LED register; reset blanks the LEDs and drops the
  // latched selection so only a fresh strobe relights them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      pos_q   <= '0;
      valid_q <= 1'b0;
      led     <= LED_OFF;
    end else begin
      sel_q   <= sel_nxt;
      pos_q   <= pos_nxt;
      valid_q <= valid_nxt;
      led     <= led_nxt;
    end
  end

endmodule
